fc_neuron_mac: RTL and testbench

//  Single-neuron multiply-accumulate stage of the fully connected layer.
//  - Streams N_INPUTS (activation, weight) pairs and adds a per-neuron bias.
//  - Rescales and saturates the sum back to WIDTH-bit fixed point.
//  - Presents the pre-activation result, via valid/ready, to the relu stage directly downstream.

---
 rtl/fc_neuron_mac.sv | 134 +++++++++++++
 tb/tb_fc_neuron_mac.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_neuron_mac.sv
// fc_neuron_mac
//   Single-neuron multiply-accumulate stage of the fully connected layer.
//   A start pulse latches the bias. N_INPUTS (activation, weight) beats are then
//   accumulated at full precision. The sum is rescaled back to Q(WIDTH-FRAC).FRAC,
//   saturated, and handed to the downstream relu stage over valid/ready.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, bias           start pulse (honoured only in IDLE); bias is sampled with it
//   in_valid, in_ready    input beat handshake for data_in / weight_in
//   data_in, weight_in    signed activation and weight
//   out_valid, out_ready  result handshake for data_out
//   data_out              signed saturated pre-activation sum
//   busy                  high whenever the FSM is not in IDLE
//   state_dbg             current FSM state (IDLE=0, ACC=1, SCALE=2, DONE=3)
//
// Handshake rule: a transfer occurs on a rising edge where valid and ready are
// both high. A source holds valid and its payload stable until that edge.
// Ready never depends combinationally on valid.
module fc_neuron_mac #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int N_INPUTS = 64,
  parameter int ACC_W    = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic signed [WIDTH-1:0] weight_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    busy,
  output logic [1:0]              state_dbg
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Saturation bounds of the WIDTH-bit result, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

  logic [1:0]               state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   scaled;
  logic signed [WIDTH-1:0]   sat_val;

  // The bias is aligned to the product's 2*FRAC fractional bits. This lets
  // bias and products share one accumulator without any intermediate rounding.
  always_comb begin
    prod     = data_in * weight_in;
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'(bias) <<< FRAC;
    // Arithmetic shift drops FRAC fractional bits and rounds toward -inf.
    scaled   = acc >>> FRAC;
    sat_val  = scaled[WIDTH-1:0];
    if (scaled > SAT_MAX) begin
      sat_val = SAT_MAX[WIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      sat_val = SAT_MIN[WIDTH-1:0];
    end
  end

  // in_ready and busy decode the state register only, so every output is
  // driven from flops.
  assign in_ready  = (state == S_ACC);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A beat presented together with start is not consumed, because
          // in_ready is low in IDLE.
          if (start) begin
            acc   <= bias_ext;
            count <= '0;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          if (in_valid) begin
            acc   <= acc + prod_ext;
            count <= count + CNT_W'(1);
            if (count == LAST_BEAT) begin
              state <= S_SCALE;
            end
          end
        end
        S_SCALE: begin
          data_out  <= sat_val;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          // data_out keeps the last result after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_neuron_mac.sv
// tb_fc_neuron_mac
//   Directed bench for fc_neuron_mac, built with N_INPUTS=4. Each scenario task
//   drives stimulus and checks results against hand-computed constants.
module tb_fc_neuron_mac;

  localparam int WIDTH = 16;
  localparam int N     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  bias = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  data_in = '0;
  logic [WIDTH-1:0]  weight_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  data_out;
  logic              busy;
  logic [1:0]        state_dbg;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];

  fc_neuron_mac #(.WIDTH(16), .FRAC(8), .N_INPUTS(N), .ACC_W(40)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .weight_in (weight_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [WIDTH-1:0] b, input logic with_beat);
    start     = 1'b1;
    bias      = b;
    in_valid  = with_beat;
    data_in   = 16'h7FFF;
    weight_in = 16'h7FFF;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    bias     = '0;
  endtask

  // Sends N beats with optional random idle gaps. Returns when the last beat
  // has been accepted (1 time unit after the accepting edge).
  task automatic send_beats(input logic [WIDTH-1:0] d[N], input logic [WIDTH-1:0] w[N],
                            input int gap_max, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
      end
      in_valid  = 1'b1;
      data_in   = d[i];
      weight_in = w[i];
      for (int b = 0; b < 20 && !in_ready; b++) tick();
      if (!in_ready) ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Waits for out_valid. lat is the number of edges waited, or -1 on timeout.
  task automatic wait_out(output logic [WIDTH-1:0] res, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res = data_out;
    if (!out_valid) lat = -1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    in_valid = 1'b1;
    #2;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (data_out !== 16'h0000) $display("FAIL reset_data_out got %h exp 0000", data_out); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (state_dbg !== 2'd0) $display("FAIL reset_state got %0d exp 0", state_dbg); else pass_cnt++;
    #11 rst_n = 1'b1;
    tick();
    // in_valid in IDLE without start is ignored.
    chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_ignore_beat busy got %b exp 0", busy); else pass_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] d[N];
    logic [WIDTH-1:0] w[N];
    bit ok;
    d = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    w = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
    out_ready = 1'b1;
    do_start(16'h0100, 1'b0);
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_acc_ready got %b exp 1", in_ready); else pass_cnt++;
    send_beats(d, w, 0, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL basic_beats_accepted got %b exp 1", ok); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_scale_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_scale_ready got %b exp 0", in_ready); else pass_cnt++;
    tick();
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", out_valid); else pass_cnt++;
    chk_cnt++; if (data_out !== 16'h0300) $display("FAIL basic_data got %h exp 0300", data_out); else pass_cnt++;
    tick();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (data_out !== 16'h0300) $display("FAIL basic_data_hold got %h exp 0300", data_out); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_negative();
    logic [WIDTH-1:0] d[N];
    logic [WIDTH-1:0] res;
    bit ok;
    int lat;
    d = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    do_start(16'hFB00, 1'b0);
    send_beats(d, d, 0, ok);
    wait_out(res, lat);
    chk_cnt++; if (lat !== 1) $display("FAIL neg_latency got %0d exp 1", lat); else pass_cnt++;
    chk_cnt++; if (res !== 16'hFF00) $display("FAIL neg_data got %h exp ff00", res); else pass_cnt++;
    tick();
  endtask

  task automatic test_saturation();
    logic [WIDTH-1:0] d[N];
    logic [WIDTH-1:0] w[N];
    logic [WIDTH-1:0] res;
    bit ok;
    int lat;
    d = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    do_start(16'h7FFF, 1'b0);
    send_beats(d, d, 0, ok);
    wait_out(res, lat);
    chk_cnt++; if (res !== 16'h7FFF) $display("FAIL sat_pos got %h exp 7fff", res); else pass_cnt++;
    tick();
    w = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    do_start(16'h7FFF, 1'b0);
    send_beats(d, w, 0, ok);
    wait_out(res, lat);
    chk_cnt++; if (res !== 16'h8000) $display("FAIL sat_neg got %h exp 8000", res); else pass_cnt++;
    tick();
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] d[N];
    logic [WIDTH-1:0] w[N];
    logic [WIDTH-1:0] res;
    bit ok;
    int lat;
    int bad_data;
    int bad_valid;
    int bad_ready;
    d = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    w = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
    bad_data = 0; bad_valid = 0; bad_ready = 0;
    out_ready = 1'b0;
    do_start(16'h0100, 1'b0);
    send_beats(d, w, 3, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL stall_beats_accepted got %b exp 1", ok); else pass_cnt++;
    wait_out(res, lat);
    chk_cnt++; if (res !== 16'h0300) $display("FAIL stall_data got %h exp 0300", res); else pass_cnt++;
    // Hold off the consumer for 5 cycles while poking start and in_valid.
    for (int c = 0; c < 5; c++) begin
      start     = (c == 1);
      bias      = 16'h4000;
      in_valid  = 1'b1;
      data_in   = 16'h1234;
      weight_in = 16'h1234;
      tick();
      if (data_out !== 16'h0300) bad_data++;
      if (out_valid !== 1'b1) bad_valid++;
      if (in_ready !== 1'b0) bad_ready++;
    end
    start = 1'b0; in_valid = 1'b0; bias = '0;
    chk_cnt++; if (bad_data !== 0) $display("FAIL stall_data_stable got %0d bad cycles exp 0", bad_data); else pass_cnt++;
    chk_cnt++; if (bad_valid !== 0) $display("FAIL stall_valid_held got %0d bad cycles exp 0", bad_valid); else pass_cnt++;
    chk_cnt++; if (bad_ready !== 0) $display("FAIL stall_in_ready_low got %0d bad cycles exp 0", bad_ready); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_handshake got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL stall_start_ignored busy got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [WIDTH-1:0] d[N];
    logic [WIDTH-1:0] w[N];
    logic [WIDTH-1:0] res;
    bit ok;
    int lat;
    d = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    w = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
    do_start(16'h0300, 1'b0);
    in_valid  = 1'b1;
    data_in   = 16'h0400;
    weight_in = 16'h0400;
    tick();
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL abort_in_ready got %b exp 0", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (data_out !== 16'h0000) $display("FAIL abort_data_out got %h exp 0000", data_out); else pass_cnt++;
    #3 rst_n = 1'b1;
    tick();
    do_start(16'h0100, 1'b0);
    send_beats(d, w, 0, ok);
    wait_out(res, lat);
    chk_cnt++; if (res !== 16'h0300) $display("FAIL abort_fresh_data got %h exp 0300", res); else pass_cnt++;
    chk_cnt++; if (lat !== 1) $display("FAIL abort_fresh_latency got %0d exp 1", lat); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d1[N];
    logic [WIDTH-1:0] w1[N];
    logic [WIDTH-1:0] d2[N];
    logic [WIDTH-1:0] w2[N];
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] exp_v;
    bit ok;
    int lat;
    // 2.0 + 1.5 - 2.0 - 0.5 + 1.5 = 2.5
    d1 = '{16'h0180, 16'hFF00, 16'h0040, 16'h0300};
    w1 = '{16'h0100, 16'h0200, 16'hFE00, 16'h0080};
    exp_q.push_back(16'h0280);
    // -0.5 + 0.25 + 0.25 - 0.25 - 2^-16 floors to -65/256
    d2 = '{16'h0100, 16'h0100, 16'h0100, 16'h0001};
    w2 = '{16'h0040, 16'h0040, 16'hFFC0, 16'hFFFF};
    exp_q.push_back(16'hFFBF);
    out_ready = 1'b1;
    // Beat presented with start must not be consumed.
    do_start(16'h0200, 1'b1);
    send_beats(d1, w1, 0, ok);
    wait_out(res, lat);
    exp_v = exp_q.pop_front();
    chk_cnt++; if (res !== exp_v) $display("FAIL b2b_first got %h exp %h", res, exp_v); else pass_cnt++;
    tick();
    do_start(16'hFF80, 1'b0);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL b2b_restart busy got %b exp 1", busy); else pass_cnt++;
    send_beats(d2, w2, 0, ok);
    wait_out(res, lat);
    exp_v = exp_q.pop_front();
    chk_cnt++; if (res !== exp_v) $display("FAIL b2b_second got %h exp %h", res, exp_v); else pass_cnt++;
    chk_cnt++; if (lat !== 1) $display("FAIL b2b_latency got %0d exp 1", lat); else pass_cnt++;
    tick();
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL b2b_queue_empty got %0d exp 0", exp_q.size()); else pass_cnt++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
